bp_update_ctrl: RTL and testbench
=================================

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set update-queue entries (power of two, 2..16).
REQ-002 Parameter MAX_DEFER, default 3, SHALL set the maximum consecutive write deferrals before a forced issue.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset; one clock, asynchronous, active-low.
REQ-005 res_valid  input  1  execute stage presents a resolved branch.
REQ-006 res_pc  input  16  PC of the resolved branch.
REQ-007 res_taken  input  1  resolved outcome (1 = taken).
REQ-008 res_ready  output  1  queue can accept; a transfer occurs when res_valid and res_ready are both high at a rising edge.
REQ-009 fetch_valid  input  1  fetch stage is reading the predictor this cycle.
REQ-010 fetch_pc  input  16  PC being read by fetch.
REQ-011 flush  input  1  synchronous discard of all pending updates.
REQ-012 pred_pc_write  output  16  PC driven to the predictor write port.
REQ-013 pred_outcome  output  1  outcome driven to the predictor.
REQ-014 pred_write_enabled  output  1  one-cycle predictor write strobe.
REQ-015 busy  output  1  high when the queue is non-empty or a write strobe is active.
REQ-016 issue_count  output  16  number of writes issued, wrapping modulo 2^16.

Function
REQ-017 Queue SHALL be a circular FIFO of {pc[15:0], taken} with head and tail pointers and a count of 0..DEPTH.
REQ-018 res_ready SHALL equal (count < DEPTH) and not flush, driven combinationally from registered state.
REQ-019 FSM states SHALL be EMPTY (count = 0), ISSUE (count > 0, no conflict or forced), and DEFER (count > 0, conflict, defer_cnt < MAX_DEFER).
REQ-020 A conflict SHALL exist when fetch_valid = 1 and fetch_pc[8:2] = head pc[8:2].
REQ-021 In ISSUE, the head SHALL be popped at the clock edge, and pred_pc_write, pred_outcome and pred_write_enabled = 1 SHALL be registered from it, so the strobe is high for exactly the following cycle.
REQ-022 In DEFER, no pop SHALL occur, defer_cnt SHALL increment, and pred_write_enabled SHALL be 0 the next cycle.
REQ-023 When defer_cnt = MAX_DEFER, the head SHALL be issued regardless of conflict, and defer_cnt SHALL clear on every pop.
REQ-024 At most one pop SHALL occur per cycle, so pred_write_enabled can be high on back-to-back cycles.
REQ-025 Minimum latency SHALL be: an entry accepted into an empty queue at edge N is popped at edge N+1, with the strobe high in the cycle after edge N+1.
REQ-026 A simultaneous push and pop SHALL leave count unchanged, and a push when full is impossible because res_ready = 0.
REQ-027 Entries SHALL issue in acceptance order, and pointers SHALL wrap from DEPTH-1 to 0.
REQ-028 When pred_write_enabled = 0, pred_pc_write and pred_outcome SHALL hold their last values.
REQ-029 issue_count SHALL increment by 1 on each pop.
REQ-030 A flush at edge N SHALL set count = 0, head = tail = 0 and defer_cnt = 0, SHALL ignore any concurrent push and pop, and SHALL make pred_write_enabled 0 in the following cycle.
REQ-031 A strobe already high in the cycle flush is sampled SHALL complete unaltered.

Reset
REQ-032 When reset = 0, all state SHALL clear asynchronously: count, head, tail, defer_cnt and issue_count = 0, FSM = EMPTY, pred_pc_write = 0, pred_outcome = 0, pred_write_enabled = 0.
REQ-033 During reset, res_ready = 0 and busy = 0.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries, and a strobe in flight SHALL drop immediately.
REQ-035 After reset deasserts, res_ready SHALL be 1 at the first rising edge.

Verification
REQ-036 Single update: push pc=0x0104, taken=1 into an empty queue at edge 1 -> pred_write_enabled = 1 with pred_pc_write = 0x0104 and pred_outcome = 1 in the cycle after edge 2; issue_count = 1.
REQ-037 Fill and ordering: 5 consecutive pushes with DEPTH = 4, fetch_valid = 0 -> res_ready drops after the queue holds 4 entries; writes appear in push order on consecutive cycles; no entry is lost.
REQ-038 Conflict deferral: head pc=0x0020, fetch_valid = 1 with fetch_pc = 0x0220 held -> no strobe for 3 cycles, then forced issue of 0x0020 on the 4th.
REQ-039 Conflict clearing: same setup, fetch_valid drops after 1 cycle -> issue on the next edge; defer_cnt returns to 0.
REQ-040 Flush: 3 entries queued plus a simultaneous push with flush -> count = 0, no further strobes, busy = 0 the cycle after any in-flight strobe.
REQ-041 Async reset: reset asserted between clock edges with 2 entries queued -> all outputs 0 immediately; after release, the first push issues normally and issue_count restarts from 1.

Source files
------------

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller: buffers resolved branches in a small FIFO and
// writes them into the predictor one per cycle, deferring while fetch reads the same index.
module bp_update_ctrl #(
    parameter int DEPTH     = 4,
    parameter int MAX_DEFER = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        res_valid,
    input  logic [15:0] res_pc,
    input  logic        res_taken,
    output logic        res_ready,
    input  logic        fetch_valid,
    input  logic [15:0] fetch_pc,
    input  logic        flush,
    output logic [15:0] pred_pc_write,
    output logic        pred_outcome,
    output logic        pred_write_enabled,
    output logic        busy,
    output logic [15:0] issue_count,
    output logic [1:0]  state_dbg
);

    localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

    localparam logic [PW-1:0] PTR_MAX   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEPTH);
    localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DEFER = 2'd2
    } state_e;

    logic [15:0]   pc_mem_q    [DEPTH];
    logic [15:0]   pc_mem_d    [DEPTH];
    logic          taken_mem_q [DEPTH];
    logic          taken_mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] defer_cnt_q, defer_cnt_d;
    state_e        state_q, state_d;
    logic [15:0]   pred_pc_q, pred_pc_d;
    logic          pred_outcome_q, pred_outcome_d;
    logic          pred_we_q, pred_we_d;
    logic [15:0]   issue_count_q, issue_count_d;

    logic [15:0] head_pc;
    logic        head_taken;
    logic        conflict;
    logic        forced;
    logic        push;
    logic        pop;
    state_e      action;

    // Only the predictor index bits [8:2] of fetch_pc take part in conflict detection.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_pc[15:9], fetch_pc[1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // Handshake: a resolved branch transfers on a rising edge where res_valid && res_ready;
    // res_ready depends only on registered occupancy, reset and flush, never on res_valid.
    assign res_ready = reset && (count_q < CNT_MAX) && !flush;

    always_comb begin
        head_pc    = pc_mem_q[head_q];
        head_taken = taken_mem_q[head_q];
        conflict   = fetch_valid && (fetch_pc[8:2] == head_pc[8:2]);
        forced     = (defer_cnt_q == DEFER_MAX);
        if (count_q == '0) begin
            action = ST_EMPTY;
        end else if (!conflict || forced) begin
            action = ST_ISSUE;
        end else begin
            action = ST_DEFER;
        end
        push = res_valid && res_ready;
        pop  = (action == ST_ISSUE);
    end

    always_comb begin
        pc_mem_d       = pc_mem_q;
        taken_mem_d    = taken_mem_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        defer_cnt_d    = defer_cnt_q;
        state_d        = action;
        pred_pc_d      = pred_pc_q;
        pred_outcome_d = pred_outcome_q;
        pred_we_d      = 1'b0;
        issue_count_d  = issue_count_q;

        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            defer_cnt_d = '0;
            state_d     = ST_EMPTY;
        end else begin
            if (push) begin
                pc_mem_d[tail_q]    = res_pc;
                taken_mem_d[tail_q] = res_taken;
                tail_d              = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d         = ptr_inc(head_q);
                pred_pc_d      = head_pc;
                pred_outcome_d = head_taken;
                pred_we_d      = 1'b1;
                defer_cnt_d    = '0;
                issue_count_d  = issue_count_q + 16'd1;
            end else if (action == ST_DEFER) begin
                defer_cnt_d = defer_cnt_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                taken_mem_q[i] <= 1'b0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            defer_cnt_q    <= '0;
            state_q        <= ST_EMPTY;
            pred_pc_q      <= '0;
            pred_outcome_q <= 1'b0;
            pred_we_q      <= 1'b0;
            issue_count_q  <= '0;
        end else begin
            pc_mem_q       <= pc_mem_d;
            taken_mem_q    <= taken_mem_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            defer_cnt_q    <= defer_cnt_d;
            state_q        <= state_d;
            pred_pc_q      <= pred_pc_d;
            pred_outcome_q <= pred_outcome_d;
            pred_we_q      <= pred_we_d;
            issue_count_q  <= issue_count_d;
        end
    end

    assign pred_pc_write      = pred_pc_q;
    assign pred_outcome       = pred_outcome_q;
    assign pred_write_enabled = pred_we_q;
    assign busy               = (count_q != '0) || pred_we_q;
    assign issue_count        = issue_count_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: directed scenarios plus random traffic,
// all compared against a queue-based model of the update rules.
module tb_bp_update_ctrl;

    localparam int DEPTH     = 4;
    localparam int MAX_DEFER = 3;

    logic        clk;
    logic        reset;
    logic        res_valid;
    logic [15:0] res_pc;
    logic        res_taken;
    logic        res_ready;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic        flush;
    logic [15:0] pred_pc_write;
    logic        pred_outcome;
    logic        pred_write_enabled;
    logic        busy;
    logic [15:0] issue_count;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [16:0] exp_q[$];
    int          m_defer = 0;
    logic        m_we = 1'b0;
    logic [15:0] m_pc = '0;
    logic        m_out = 1'b0;
    logic [15:0] m_cnt = '0;
    logic        m_pushed = 1'b0;

    bp_update_ctrl #(.DEPTH(DEPTH), .MAX_DEFER(MAX_DEFER)) dut (
        .clk                (clk),
        .reset              (reset),
        .res_valid          (res_valid),
        .res_pc             (res_pc),
        .res_taken          (res_taken),
        .res_ready          (res_ready),
        .fetch_valid        (fetch_valid),
        .fetch_pc           (fetch_pc),
        .flush              (flush),
        .pred_pc_write      (pred_pc_write),
        .pred_outcome       (pred_outcome),
        .pred_write_enabled (pred_write_enabled),
        .busy               (busy),
        .issue_count        (issue_count),
        .state_dbg          (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_defer  = 0;
        m_we     = 1'b0;
        m_pc     = '0;
        m_out    = 1'b0;
        m_cnt    = '0;
        m_pushed = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic [15:0] hpc;
        logic        conf;
        m_pushed = 1'b0;
        m_we     = 1'b0;
        if (flush) begin
            exp_q.delete();
            m_defer = 0;
        end else begin
            m_pushed = res_valid && (exp_q.size() < DEPTH);
            if (exp_q.size() > 0) begin
                hpc  = exp_q[0][16:1];
                conf = fetch_valid && (fetch_pc[8:2] == hpc[8:2]);
                if (!conf || m_defer == MAX_DEFER) begin
                    m_we    = 1'b1;
                    m_pc    = hpc;
                    m_out   = exp_q[0][0];
                    m_cnt   = m_cnt + 16'd1;
                    m_defer = 0;
                    void'(exp_q.pop_front());
                end else begin
                    m_defer++;
                end
            end
            if (m_pushed) exp_q.push_back({res_pc, res_taken});
        end
    endtask

    task automatic compare_outputs();
        check("res_ready", res_ready, (exp_q.size() < DEPTH) && !flush);
        check("busy", busy, (exp_q.size() != 0) || m_we);
        check("pred_we", pred_write_enabled, m_we);
        check("pred_pc", pred_pc_write, m_pc);
        check("pred_outcome", pred_outcome, m_out);
        check("issue_count", issue_count, m_cnt);
    endtask

    // Driver: apply one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic cycle(input logic v, input logic [15:0] pc, input logic tk,
                         input logic fv, input logic [15:0] fpc, input logic fl);
        @(negedge clk);
        res_valid   = v;
        res_pc      = pc;
        res_taken   = tk;
        fetch_valid = fv;
        fetch_pc    = fpc;
        flush       = fl;
        #1;
        compare_outputs();
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset       = 1'b0;
        res_valid   = 1'b0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        #1;
        check("rst_pred_we", pred_write_enabled, 1'b0);
        check("rst_pred_pc", pred_pc_write, 16'h0);
        check("rst_pred_out", pred_outcome, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", res_ready, 1'b0);
        check("rst_issue_cnt", issue_count, 16'h0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic       saw_full;
        logic       v, tk, fv, fl;
        logic [15:0] pc, fpc;
        int         i;

        reset = 1'b0; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0; flush = 1'b0;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("init_ready", res_ready, 1'b0);
        check("init_busy", busy, 1'b0);
        check("init_pred_we", pred_write_enabled, 1'b0);
        check("init_issue_cnt", issue_count, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", res_ready, 1'b1);

        // Single update: minimum latency
        cycle(1'b1, 16'h0104, 1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        check("single_we", pred_write_enabled, 1'b1);
        check("single_pc", pred_pc_write, 16'h0104);
        check("single_out", pred_outcome, 1'b1);
        check("single_cnt", issue_count, 16'd1);
        idle(2);
        check("hold_pc", pred_pc_write, 16'h0104);

        // Fill and ordering: conflicting fetch keeps the queue from draining
        saw_full = 1'b0;
        i = 0;
        while (i < 5) begin
            cycle(1'b1, 16'h0100 + 16'(i << 9), i[0], 1'b1, 16'h0100, 1'b0);
            if (!res_ready) saw_full = 1'b1;
            if (m_pushed) i++;
        end
        check("fill_full", saw_full, 1'b1);
        idle(7);
        check("fill_cnt", issue_count, 16'd6);

        // Conflict deferral: forced issue after MAX_DEFER stalls
        cycle(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'h0220, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        check("defer_pc", pred_pc_write, 16'h0020);
        check("defer_cnt", issue_count, 16'd7);

        // Conflict clearing
        cycle(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'h0220, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        check("clear_we", pred_write_enabled, 1'b1);
        check("clear_out", pred_outcome, 1'b1);
        // A fresh conflicting head must again get the full deferral budget
        cycle(1'b1, 16'h0024, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'h0424, 1'b0);

        // Flush with three queued entries and a concurrent push
        cycle(1'b1, 16'h0040, 1'b0, 1'b1, 16'h0040, 1'b0);
        cycle(1'b1, 16'h0240, 1'b1, 1'b1, 16'h0040, 1'b0);
        cycle(1'b1, 16'h0440, 1'b0, 1'b1, 16'h0040, 1'b0);
        cycle(1'b1, 16'h0640, 1'b1, 1'b1, 16'h0040, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        check("flush_busy", busy, 1'b0);
        check("flush_ready", res_ready, 1'b1);
        idle(3);
        check("flush_no_we", pred_write_enabled, 1'b0);

        // Async reset with two entries and a strobe in flight
        cycle(1'b1, 16'h0080, 1'b1, 1'b1, 16'h0080, 1'b0);
        cycle(1'b1, 16'h0280, 1'b0, 1'b1, 16'h0080, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        async_reset();
        cycle(1'b1, 16'h0104, 1'b1, 1'b0, 16'h0, 1'b0);
        idle(2);
        check("post_rst_cnt", issue_count, 16'd1);
        check("post_rst_pc", pred_pc_write, 16'h0104);

        // Random traffic with a small PC alphabet so conflicts are frequent
        for (int n = 0; n < 800; n++) begin
            v   = ($urandom_range(0, 99) < 60);
            pc  = 16'($urandom_range(0, 7) << 2) | 16'($urandom_range(0, 3) << 9);
            tk  = 1'($urandom_range(0, 1));
            fv  = ($urandom_range(0, 99) < 55);
            fpc = 16'($urandom_range(0, 7) << 2) | 16'($urandom_range(0, 3) << 9);
            fl  = ($urandom_range(0, 99) < 3);
            cycle(v, pc, tk, fv, fpc, fl);
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
